// File: rtl/seg7_pkg.sv
// Shared types, font and sizing helpers for the seg7_led_bin_mux display driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_e;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;

  // Active-high gfedcba; index 0 is the rightmost entry. Codes 10..15 are blank.
  localparam logic [15:0][6:0] FONT = {
    {6{GLYPH_BLANK}},
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Decimal digits needed to hold any w-bit binary value, plus one spare.
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w * 3 + 9) / 10 + 1;
  endfunction

endpackage

// File: rtl/bin_2_bcd_seq.sv
// Sequential double-dabble converter with valid/ready intake and a one-cycle done pulse.
module bin_2_bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned BCD_W     = 4 * bcd_digits(BIN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic                 bin_valid_i,
  output logic                 bin_ready_o,
  output logic [BCD_W-1:0]     bcd_o,
  output logic                 done_o
);

  localparam int unsigned ND = BCD_W / 4;
  localparam int unsigned CW = $clog2(BIN_WIDTH + 1);

  conv_state_e            state_q;
  logic                   ready_q;
  logic                   done_q;
  logic [CW-1:0]          cnt_q;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
    bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (bin_valid_i && ready_q) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= CW'(BIN_WIDTH);
            ready_q <= 1'b0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - 1'b1;
          // done rises with the last shift so the consumer captures on the LOAD edge
          if (cnt_q == CW'(1)) begin
            state_q <= LOAD;
            done_q  <= 1'b1;
          end
        end
        LOAD: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bin_ready_o = ready_q;
  assign bcd_o       = bcd_q;
  assign done_o      = done_q;

endmodule

// File: rtl/seg7_led_bin_mux.sv
// N-digit multiplexed 7-segment driver fed by a binary value via valid/ready.
// Optional leading-zero blanking with macro SEG7_LZB_EN.
module seg7_led_bin_mux
  import seg7_pkg::*;
#(
  parameter int unsigned BIN_WIDTH      = 16,
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic                 bin_valid_i,
  output logic                 bin_ready_o,
  input  logic [DIGITS-1:0]    dp_i,
  output logic                 ovf_o,
  output logic [DIGITS-1:0]    sel,
  output logic [7:0]           seg_led
);

  localparam int unsigned BCD_W  = 4 * bcd_digits(BIN_WIDTH);
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [BCD_W-1:0]        bcd;
  logic                    conv_done;
  logic [BCD_W+DISP_W-1:0] bcd_ext;

  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        glyph;
  logic              dp_bit;
  logic [7:0]        seg_act;
  logic [DIGITS-1:0] onehot;

  bin_2_bcd_seq #(
    .BIN_WIDTH (BIN_WIDTH),
    .BCD_W     (BCD_W)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .bin_i       (bin_i),
    .bin_valid_i (bin_valid_i),
    .bin_ready_o (bin_ready_o),
    .bcd_o       (bcd),
    .done_o      (conv_done)
  );

  // Zero-extension lets the overflow OR cover any BCD/DIGITS width relation.
  assign bcd_ext = {{DISP_W{1'b0}}, bcd};

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done) begin
      disp_d = bcd_ext[DISP_W-1:0];
      ovf_d  = |(bcd_ext >> DISP_W);
    end

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Outputs are derived from next-state values so sel/seg track the counters exactly.
    nib   = 4'(disp_d >> (4 * idx_d));
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    blank = (idx_d != '0) && ((disp_d >> (4 * idx_d)) == '0);
`endif

    if (ovf_d) begin
      glyph  = GLYPH_DASH;
      dp_bit = 1'b0;
    end else begin
      glyph  = blank ? GLYPH_BLANK : FONT[nib];
      dp_bit = dp_i[idx_d];
    end

    seg_act = {dp_bit, glyph};
    onehot  = (presc_d == PRESC_LAST) ? '0 : (DIGITS'(1) << idx_d);
    seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    sel_d   = SEL_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= {DIGITS{SEL_ACTIVE_LOW}};
      seg_q   <= {8{SEG_ACTIVE_LOW}};
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign ovf_o   = ovf_q;
  assign sel     = sel_q;
  assign seg_led = seg_q;

endmodule

// File: tb/tb_seg7_led_bin_mux.sv
// Directed bench for seg7_led_bin_mux: vector table plus latency, ignore, reset and back-to-back sequences.
module tb_seg7_led_bin_mux;

`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bin_i = '0;
  logic        bin_valid_i = 1'b0;
  logic        bin_ready_o;
  logic [3:0]  dp_i = '0;
  logic        ovf_o;
  logic [3:0]  sel;
  logic [7:0]  seg_led;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_led_bin_mux #(
    .BIN_WIDTH      (16),
    .DIGITS         (4),
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bin_i       (bin_i),
    .bin_valid_i (bin_valid_i),
    .bin_ready_o (bin_ready_o),
    .dp_i        (dp_i),
    .ovf_o       (ovf_o),
    .sel         (sel),
    .seg_led     (seg_led)
  );

  // Expected segs packed {digit3, digit2, digit1, digit0}, active-low.
  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        ovf;
    logic [31:0] seg_plain;
    logic [31:0] seg_lzb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bin_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 32'(bin_ready_o), 32'd1);
  endtask

  task automatic load(input string name, input logic [15:0] v);
    wait_ready({name, " pre"});
    bin_i       = v;
    bin_valid_i = 1'b1;
    @(negedge clk);
    bin_valid_i = 1'b0;
    @(negedge clk);
    wait_ready({name, " post"});
  endtask

  task automatic scan_check(input string name, input logic [31:0] exp);
    int cnt[4];
    int offs, bad, d;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    offs = 0;
    bad  = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = -1;
      case (sel)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        4'b1111: offs++;
        default: bad++;
      endcase
      if (d >= 0) begin
        cnt[d]++;
        chk($sformatf("%s d%0d", name, d), 32'(seg_led), 32'(exp[8*d +: 8]));
      end
    end
    chk({name, " slots"},
        32'({4'(bad), 4'(cnt[3]), 4'(cnt[2]), 4'(cnt[1]), 4'(cnt[0]), 4'(offs)}),
        32'h0003_3334);
  endtask

  function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] lzb);
    return LZB ? lzb : plain;
  endfunction

  initial begin
    logic [17:0] rb, ob;
    int acc;

    vecs[0]  = '{16'd1234,  4'b0000, 1'b0, 32'hF9A4B099, 32'hF9A4B099};
    vecs[1]  = '{16'd12345, 4'b0000, 1'b1, 32'hBFBFBFBF, 32'hBFBFBFBF};
    vecs[2]  = '{16'd9999,  4'b0000, 1'b0, 32'h90909090, 32'h90909090};
    vecs[3]  = '{16'd7,     4'b0000, 1'b0, 32'hC0C0C0F8, 32'hFFFFFFF8};
    vecs[4]  = '{16'd0,     4'b0010, 1'b0, 32'hC0C040C0, 32'hFFFF7FC0};
    vecs[5]  = '{16'd100,   4'b0000, 1'b0, 32'hC0F9C0C0, 32'hFFF9C0C0};
    vecs[6]  = '{16'd35,    4'b0000, 1'b0, 32'hC0C0B092, 32'hFFFFB092};
    vecs[7]  = '{16'd8060,  4'b0000, 1'b0, 32'h80C082C0, 32'h80C082C0};
    vecs[8]  = '{16'd1000,  4'b1000, 1'b0, 32'h79C0C0C0, 32'h79C0C0C0};
    vecs[9]  = '{16'd10000, 4'b1111, 1'b1, 32'hBFBFBFBF, 32'hBFBFBFBF};
    vecs[10] = '{16'd9999,  4'b1111, 1'b0, 32'h10101010, 32'h10101010};
    vecs[11] = '{16'd65535, 4'b0000, 1'b1, 32'hBFBFBFBF, 32'hBFBFBFBF};
    vecs[12] = '{16'd1234,  4'b0000, 1'b0, 32'hF9A4B099, 32'hF9A4B099};

    // Reset
    repeat (3) @(negedge clk);
    chk("rst sel",   32'(sel),         32'hF);
    chk("rst seg",   32'(seg_led),     32'hFF);
    chk("rst ovf",   32'(ovf_o),       32'd0);
    chk("rst ready", 32'(bin_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", 32'(bin_ready_o), 32'd1);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      dp_i = vecs[i].dp;
      load($sformatf("v%0d", i), vecs[i].val);
      chk($sformatf("v%0d ovf", i), 32'(ovf_o), 32'(vecs[i].ovf));
      scan_check($sformatf("v%0d", i), pick(vecs[i].seg_plain, vecs[i].seg_lzb));
    end

    // Latency: ready low after edges 0..16, ovf and ready update on edge 17
    dp_i = '0;
    wait_ready("lat");
    bin_i       = 16'd12345;
    bin_valid_i = 1'b1;
    rb = '0;
    ob = '0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) bin_valid_i = 1'b0;
      rb[k] = bin_ready_o;
      ob[k] = ovf_o;
    end
    chk("lat ready", 32'(rb), 32'h20000);
    chk("lat ovf",   32'(ob), 32'h20000);
    scan_check("lat", 32'hBFBFBFBF);

    // Valid while busy is ignored
    wait_ready("ign");
    bin_i       = 16'd1234;
    bin_valid_i = 1'b1;
    @(negedge clk);
    bin_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    bin_i       = 16'd5678;
    bin_valid_i = 1'b1;
    @(negedge clk);
    bin_valid_i = 1'b0;
    bin_i       = '0;
    @(negedge clk);
    wait_ready("ign done");
    chk("ign ovf", 32'(ovf_o), 32'd0);
    scan_check("ign", 32'hF9A4B099);
    repeat (20) @(negedge clk);
    chk("no queue ready", 32'(bin_ready_o), 32'd1);
    scan_check("no queue", 32'hF9A4B099);

    // Reset mid-conversion aborts without a LOAD
    bin_i       = 16'd4321;
    bin_valid_i = 1'b1;
    @(negedge clk);
    bin_valid_i = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst sel",   32'(sel),         32'hF);
    chk("midrst seg",   32'(seg_led),     32'hFF);
    chk("midrst ready", 32'(bin_ready_o), 32'd0);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    chk("postrst ovf", 32'(ovf_o), 32'd0);
    scan_check("postrst", pick(32'hC0C0C0C0, 32'hFFFFFFC0));

    // Back-to-back with valid held high
    wait_ready("b2b");
    bin_i       = 16'd100;
    bin_valid_i = 1'b1;
    @(negedge clk);
    bin_i = 16'd200;
    acc   = 0;
    for (int k = 1; k < 40 && acc == 0; k++) begin
      if (bin_ready_o === 1'b1) acc = k;
      else @(negedge clk);
    end
    chk("b2b accept edge", 32'(acc), 32'd18);
    @(negedge clk);
    bin_valid_i = 1'b0;
    scan_check("b2b old", pick(32'hC0F9C0C0, 32'hFFF9C0C0));
    wait_ready("b2b new");
    chk("b2b ovf", 32'(ovf_o), 32'd0);
    scan_check("b2b new", pick(32'hC0A4C0C0, 32'hFFA4C0C0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
